// File: rtl/tetris_input.sv
// Tetris input front end: debounced buttons, UART key bytes and gravity merged into request flags,
// issued one event at a time on ctrl with a two-cycle gap. Optional macro TETRIS_AUTOREPEAT_EN adds LEFT/RIGHT auto-repeat.
package enum_type;
   typedef enum logic [3:0] {
      NOEVENT    = 4'd0,
      LEFT       = 4'd1,
      RIGHT      = 4'd2,
      DOWN       = 4'd3,
      DROP       = 4'd4,
      HOLD       = 4'd5,
      ROTATE     = 4'd6,
      ROTATE_REV = 4'd7,
      BAR        = 4'd8
   } control_type;
endpackage

module tetris_input
   import enum_type::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int GRAVITY_CYCLES  = 50_000_000,
   parameter int STALL_CYCLES    = 256,
   parameter int REPEAT_CYCLES   = 15_000_000
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  btn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        pause,
   input  logic        ready,
   output control_type ctrl,
   output logic [7:0]  pending
);

   localparam int F_LEFT = 0, F_RIGHT = 1, F_DOWN = 2, F_DROP = 3;
   localparam int F_HOLD = 4, F_ROT = 5, F_ROTREV = 6, F_BAR = 7;

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = $clog2(GRAVITY_CYCLES + 1);
   localparam int SW = $clog2(STALL_CYCLES + 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] GR_MAX = GW'(GRAVITY_CYCLES - 1);
   localparam logic [SW-1:0] ST_MAX = SW'(STALL_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   logic [3:0]    r_sync1, r_sync2, r_db;
   logic [DW-1:0] r_db_cnt [4];
   logic [3:0]    w_db_rise;
   logic [GW-1:0] r_grav_cnt;
   logic          w_grav_req;
   logic [SW-1:0] r_stall;
   logic          w_stalled;
   logic [7:0]    w_rx_req, w_req, w_sel_mask, w_clr, w_pend_nxt;
   logic [7:0]    r_pending;
   logic [1:0]    w_rep_req;
   control_type   w_sel_ctrl, r_ctrl;
   state_t        r_state, w_state_nxt;
   logic          w_issue;

   // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_MAX) begin
               r_db[i]     <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_db_rise = '0;
      for (int i = 0; i < 4; i++)
         w_db_rise[i] = ~r_db[i] & r_sync2[i] & (r_db_cnt[i] == DB_MAX);
   end

`ifdef TETRIS_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] r_rep_cnt [2];

   always_comb begin
      w_rep_req = '0;
      for (int i = 0; i < 2; i++)
         w_rep_req[i] = r_db[i] & (r_rep_cnt[i] == RP_MAX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!r_db[i] || w_rep_req[i]) r_rep_cnt[i] <= '0;
            else                          r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
         end
      end
   end
`else
   localparam int unused_repeat_cycles = REPEAT_CYCLES;
   assign w_rep_req = '0;
`endif

   always_comb begin
      w_rx_req = '0;
      if (rx_valid) begin
         case (rx_data)
            8'h61:   w_rx_req[F_LEFT]   = 1'b1;
            8'h64:   w_rx_req[F_RIGHT]  = 1'b1;
            8'h73:   w_rx_req[F_DOWN]   = 1'b1;
            8'h77:   w_rx_req[F_ROT]    = 1'b1;
            8'h7a:   w_rx_req[F_ROTREV] = 1'b1;
            8'h20:   w_rx_req[F_DROP]   = 1'b1;
            8'h63:   w_rx_req[F_HOLD]   = 1'b1;
            8'h62:   w_rx_req[F_BAR]    = 1'b1;
            default: w_rx_req = '0;
         endcase
      end
   end

   assign w_grav_req = !pause && (r_grav_cnt == GR_MAX);
   assign w_stalled  = (r_stall >= ST_MAX);

   always_comb begin
      w_req           = w_rx_req;
      w_req[F_RIGHT]  = w_req[F_RIGHT] | w_db_rise[0] | w_rep_req[0];
      w_req[F_LEFT]   = w_req[F_LEFT]  | w_db_rise[1] | w_rep_req[1];
      w_req[F_ROT]    = w_req[F_ROT]   | w_db_rise[2];
      w_req[F_DROP]   = w_req[F_DROP]  | w_db_rise[3];
      w_req[F_DOWN]   = w_req[F_DOWN]  | w_grav_req;
   end

   always_comb begin
      w_sel_ctrl = NOEVENT;
      w_sel_mask = '0;
      if      (r_pending[F_DROP])   begin w_sel_ctrl = DROP;       w_sel_mask[F_DROP]   = 1'b1; end
      else if (r_pending[F_HOLD])   begin w_sel_ctrl = HOLD;       w_sel_mask[F_HOLD]   = 1'b1; end
      else if (r_pending[F_ROT])    begin w_sel_ctrl = ROTATE;     w_sel_mask[F_ROT]    = 1'b1; end
      else if (r_pending[F_ROTREV]) begin w_sel_ctrl = ROTATE_REV; w_sel_mask[F_ROTREV] = 1'b1; end
      else if (r_pending[F_LEFT])   begin w_sel_ctrl = LEFT;       w_sel_mask[F_LEFT]   = 1'b1; end
      else if (r_pending[F_RIGHT])  begin w_sel_ctrl = RIGHT;      w_sel_mask[F_RIGHT]  = 1'b1; end
      else if (r_pending[F_DOWN])   begin w_sel_ctrl = DOWN;       w_sel_mask[F_DOWN]   = 1'b1; end
      else if (r_pending[F_BAR])    begin w_sel_ctrl = BAR;        w_sel_mask[F_BAR]    = 1'b1; end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         IDLE: begin
            if (|r_pending && (ready || w_stalled)) begin
               w_state_nxt = ISSUE;
               w_issue     = 1'b1;
            end
         end
         ISSUE:   w_state_nxt = GAP;
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Clearing wins over a same-cycle request for the issued flag, so that request is absorbed.
   assign w_clr      = w_issue ? w_sel_mask : 8'h00;
   assign w_pend_nxt = (r_pending | w_req) & ~w_clr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_ctrl     <= NOEVENT;
         r_pending  <= '0;
         r_grav_cnt <= '0;
         r_stall    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ctrl    <= w_issue ? w_sel_ctrl : NOEVENT;
         r_pending <= w_pend_nxt;
         if (!pause) r_grav_cnt <= w_grav_req ? '0 : r_grav_cnt + 1'b1;
         if (ready)                  r_stall <= '0;
         else if (r_stall != ST_MAX) r_stall <= r_stall + 1'b1;
      end
   end

   assign ctrl    = r_ctrl;
   assign pending = r_pending;

endmodule

// File: tb/tb_tetris_input.sv
// Scoreboard bench for tetris_input: directed stimulus queues expected events with cycle windows,
// a negedge monitor pops and checks every non-NOEVENT ctrl pulse and the inter-event gap.
module tb_tetris_input;
   import enum_type::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  btn = 4'h0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        pause = 1'b1;
   logic        ready = 1'b1;
   control_type ctrl;
   logic [7:0]  pending;

   tetris_input #(
      .DEBOUNCE_CYCLES(4),
      .GRAVITY_CYCLES (100),
      .STALL_CYCLES   (16),
      .REPEAT_CYCLES  (20)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .pause   (pause),
      .ready   (ready),
      .ctrl    (ctrl),
      .pending (pending)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int last_ev = -100;

   typedef struct {
      control_type c;
      int          lo;
      int          hi;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic expect_ev(input control_type c, input int lo, input int hi);
      exp_t e;
      e.c = c; e.lo = lo; e.hi = hi;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (reset_n && ctrl != NOEVENT) begin
         total++;
         if (cyc - last_ev < 3) begin
            bad++;
            $display("FAIL gap: %s at cyc %0d is %0d cycles after previous event, required >= 3",
                     ctrl.name(), cyc, cyc - last_ev);
         end
         last_ev = cyc;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s at cyc %0d, required NOEVENT", ctrl.name(), cyc);
         end else begin
            mon_e = sb.pop_front();
            if (ctrl != mon_e.c || cyc < mon_e.lo || cyc > mon_e.hi) begin
               bad++;
               $display("FAIL event: got %s at cyc %0d, required %s in cyc [%0d,%0d]",
                        ctrl.name(), cyc, mon_e.c.name(), mon_e.lo, mon_e.hi);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
   endtask

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%02h, required 0x%02h", name, got, exp);
      end
   endtask

   task automatic check_ctrl(input string name, input control_type got, input control_type exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %s, required %s", name, got.name(), exp.name());
      end
   endtask

   task automatic drain(input string name, input int n);
      step(n);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d expected events never appeared, required 0 outstanding", name, sb.size());
         sb.delete();
      end
   endtask

   logic [7:0]  keys  [10] = '{8'h20, 8'h61, 8'h61, 8'h63, 8'h77, 8'h7a, 8'h64, 8'h73, 8'h62, 8'h71};
   control_type order [8]  = '{DROP, HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DOWN, BAR};

   initial begin
      int c0;
      int c1;

      #2 reset_n = 1'b0;
      #1;
      check_ctrl("reset_ctrl", ctrl, NOEVENT);
      check8("reset_pending", pending, 8'h00);
      step(2);
      reset_n = 1'b1;
      step(5);

      // Priority order, merge of duplicate 'a', ignored byte 'q'
      c0 = cyc;
      for (int k = 0; k < 8; k++) expect_ev(order[k], c0 + 11 + 3 * k, c0 + 11 + 3 * k);
      ready = 1'b0;
      for (int i = 0; i < 10; i++) send(keys[i]);
      check8("all_flags_pending", pending, 8'hFF);
      ready = 1'b1;
      drain("priority_drain", 40);
      check8("flags_cleared", pending, 8'h00);

      // DROP then LEFT with ready held high
      c0 = cyc;
      expect_ev(DROP, c0 + 2, c0 + 2);
      expect_ev(LEFT, c0 + 5, c0 + 5);
      send(8'h20);
      send(8'h61);
      drain("drop_left_drain", 20);

      // Debounce: short glitch rejected, long press gives one LEFT
      btn[1] = 1'b1;
      step(3);
      btn[1] = 1'b0;
      step(20);
      c1 = cyc;
      expect_ev(LEFT, c1 + 7, c1 + 7);
      btn[1] = 1'b1;
      step(10);
      btn[1] = 1'b0;
      drain("debounce_drain", 30);

      // Stall override with ready low
      c0 = cyc;
      expect_ev(RIGHT, c0 + 17, c0 + 17);
      ready = 1'b0;
      send(8'h64);
      step(25);
      ready = 1'b1;
      drain("stall_drain", 10);

      // Held RIGHT button
      c0 = cyc;
      expect_ev(RIGHT, c0 + 7, c0 + 7);
`ifdef TETRIS_AUTOREPEAT_EN
      expect_ev(RIGHT, c0 + 27, c0 + 27);
      expect_ev(RIGHT, c0 + 47, c0 + 47);
      expect_ev(RIGHT, c0 + 67, c0 + 67);
`endif
      btn[0] = 1'b1;
      step(71);
      btn[0] = 1'b0;
      drain("repeat_drain", 40);

      // Gravity, free running for 1000 cycles
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(2);
      c0 = cyc;
      for (int k = 0; k < 10; k++) expect_ev(DOWN, c0 + 101 + 100 * k, c0 + 101 + 100 * k);
      pause = 1'b0;
      step(1002);
      pause = 1'b1;
      drain("gravity_drain", 5);

      // Gravity with a 50-cycle pause
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(2);
      c0 = cyc;
      expect_ev(DOWN, c0 + 101, c0 + 101);
      for (int k = 0; k < 8; k++) expect_ev(DOWN, c0 + 251 + 100 * k, c0 + 251 + 100 * k);
      pause = 1'b0;
      step(150);
      pause = 1'b1;
      step(50);
      pause = 1'b0;
      step(802);
      pause = 1'b1;
      drain("gravity_pause_drain", 60);

      // Asynchronous reset discards a pending HOLD
      ready = 1'b0;
      send(8'h63);
      check8("hold_pending", pending, 8'h10);
      step(1);
      #3 reset_n = 1'b0;
      #1;
      check8("async_reset_pending", pending, 8'h00);
      check_ctrl("async_reset_ctrl", ctrl, NOEVENT);
      step(2);
      reset_n = 1'b1;
      ready = 1'b1;
      drain("reset_drain", 20);
      check8("post_reset_pending", pending, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tetris_input.md
TETRIS_INPUT -- requirements
Module: tetris_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, cycles a synchronized button must be stable to be accepted.
REQ-002 SHALL have parameter GRAVITY_CYCLES, default 50_000_000, period of automatic DOWN requests.
REQ-003 SHALL have parameter STALL_CYCLES, default 256, consecutive ready-low cycles after which events are issued without ready.
REQ-004 SHALL have parameter REPEAT_CYCLES, default 15_000_000, auto-repeat period (REQ-024 only).
REQ-005 SHALL have ports: clk  in  1  system clock; one clock; reset is asynchronous and active-low, port reset_n.
REQ-006 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: btn  in  4  raw buttons, [0] RIGHT, [1] LEFT, [2] ROTATE, [3] DROP.
REQ-008 SHALL have ports: rx_data  in  8  received key byte; rx_valid  in  1  one-cycle byte strobe.
REQ-009 SHALL have ports: pause  in  1  freezes gravity counter; ready  in  1  game core idle/accepting.
REQ-010 SHALL have ports: ctrl  out  enum_type::control_type  issued event, NOEVENT otherwise.
REQ-011 SHALL have ports: pending  out  8  request flags, [0] LEFT [1] RIGHT [2] DOWN [3] DROP [4] HOLD [5] ROTATE [6] ROTATE_REV [7] BAR.

Function
REQ-012 SHALL synchronize btn through two flip-flops, then debounce: debounced bit updates after DEBOUNCE_CYCLES consecutive cycles of differing synchronized value.
REQ-013 SHALL set the mapped pending flag on each debounced rising edge only.
REQ-014 SHALL decode rx_valid bytes: 'a' LEFT, 'd' RIGHT, 's' DOWN, 'w' ROTATE, 'z' ROTATE_REV, ' ' DROP, 'c' HOLD, 'b' BAR; other bytes ignored.
REQ-015 SHALL count gravity cycles while pause=0, setting DOWN pending and reloading to 0 when count reaches GRAVITY_CYCLES-1; pause holds the count.
REQ-016 SHALL merge a request into an already-set flag (no counting); a request for the flag issued in the same cycle is absorbed.
REQ-017 SHALL use states IDLE, ISSUE, GAP: IDLE->ISSUE when any flag set and (ready=1 or stall count >= STALL_CYCLES); ISSUE->GAP always; GAP->IDLE always.
REQ-018 SHALL in ISSUE drive ctrl for exactly one cycle with the highest-priority flag, DROP > HOLD > ROTATE > ROTATE_REV > LEFT > RIGHT > DOWN > BAR, clearing that flag; ctrl=NOEVENT in all other states.
REQ-019 SHALL keep a saturating stall counter: increments while ready=0, clears when ready=1.
REQ-020 SHALL, in GAP, drive NOEVENT, guaranteeing at least two NOEVENT cycles between events.
REQ-021 SHALL register ctrl (output changes only on clk edge); pending reflects flags registered.

Reset
REQ-022 SHALL on reset_n=0 asynchronously force state IDLE, ctrl=NOEVENT, pending=0, gravity, stall, debounce counters 0, debounced buttons 0; reset mid-issue discards the event.

Configuration
REQ-023 SHALL compile auto-repeat only when macro TETRIS_AUTOREPEAT_EN is defined.
REQ-024 SHALL with TETRIS_AUTOREPEAT_EN re-set LEFT/RIGHT pending every REPEAT_CYCLES while the debounced button stays held (first repeat REPEAT_CYCLES after edge); without it, holding yields one request per press.

Verification
REQ-025 SHALL verify (DEBOUNCE_CYCLES=4, ready=1): btn[1] high 3 cycles then low -> no event; high 10 cycles -> exactly one ctrl=LEFT pulse.
REQ-026 SHALL verify: rx_data=' ' and 'a' strobed same window, ready=1 -> ctrl=DROP, then >=2 NOEVENT cycles, then LEFT.
REQ-027 SHALL verify (GRAVITY_CYCLES=100, ready=1): 1000 cycles -> 10 DOWN pulses; pause=1 for 50 of them -> 9 or 10 per exact count, zero during pause.
REQ-028 SHALL verify (STALL_CYCLES=16): ready=0, rx 'd' -> no event for 16 cycles, then one RIGHT pulse.
REQ-029 SHALL verify: 'c' pending, reset_n pulsed low asynchronously -> pending=0, ctrl=NOEVENT immediately, no HOLD after release.
REQ-030 SHALL verify with TETRIS_AUTOREPEAT_EN (REPEAT_CYCLES=20): btn[0] held 65 cycles after debounce -> 4 RIGHT pulses; without macro -> 1.
